// File: rtl/framebuffer_pkg.sv
// Shared types and constants for the frame-buffer scanout path.
// Default timing is 1080p60; the coordinate and colour widths match the buffer's read port.
package framebuffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SKIP = 2'd2
    } scan_state_t;

    localparam int PIXEL_COORD_W = 21;
    localparam int RGB_W         = 24;

    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_FP     = 88;
    localparam int DEF_H_SYNC   = 44;
    localparam int DEF_H_BP     = 148;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 36;

    // Per-pixel sideband carried alongside the read so it meets the returned colour.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        logic scan;
        logic last;
    } video_tag_t;

    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster counters with active-area, sync and frame-start decode.
// All decode outputs are combinational from the registered counters.
module video_timing_gen
    import framebuffer_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HW       = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [HW-1:0] hcnt_reg;
    logic [VW-1:0] vcnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else if (int'(hcnt_reg) == H_TOTAL - 1) begin
            hcnt_reg <= '0;
            if (int'(vcnt_reg) == V_TOTAL - 1) begin
                vcnt_reg <= '0;
            end else begin
                vcnt_reg <= vcnt_reg + VW'(1);
            end
        end else begin
            hcnt_reg <= hcnt_reg + HW'(1);
        end
    end

    assign hcnt        = hcnt_reg;
    assign vcnt        = vcnt_reg;
    assign active      = (int'(hcnt_reg) < H_ACTIVE) && (int'(vcnt_reg) < V_ACTIVE);
    assign hsync       = (int'(hcnt_reg) >= H_ACTIVE + H_FP) &&
                         (int'(hcnt_reg) <  H_ACTIVE + H_FP + H_SYNC);
    assign vsync       = (int'(vcnt_reg) >= V_ACTIVE + V_FP) &&
                         (int'(vcnt_reg) <  V_ACTIVE + V_FP + V_SYNC);
    assign frame_start = (hcnt_reg == '0) && (vcnt_reg == '0);

endmodule

// File: rtl/framebuffer_scanout.sv
// Scanout engine: commits or drops each frame at frame start, issues one buffer read per
// active pixel, and delays sync/blank so they leave together with the returned colour.
module framebuffer_scanout
    import framebuffer_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BP         = DEF_H_BP,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BP         = DEF_V_BP,
    parameter int READ_LATENCY = 1
) (
    input  logic                     clk_pixel,
    input  logic                     reset,
    input  logic                     ableToRead,
    input  logic [RGB_W-1:0]         readPixel,
    output logic [PIXEL_COORD_W-1:0] readPixelX,
    output logic [PIXEL_COORD_W-1:0] readPixelY,
    output logic                     readPixelSignal,
    output logic                     endOfRead,
    output logic [7:0]               vga_r,
    output logic [7:0]               vga_g,
    output logic [7:0]               vga_b,
    output logic                     vga_hsync,
    output logic                     vga_vsync,
    output logic                     vga_blank,
    output logic                     underflow
);

    localparam int HW     = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW     = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int PIPE_D = READ_LATENCY + 1;

    localparam video_tag_t TAG_RESET = '{hsync: 1'b0, vsync: 1'b0, blank: 1'b1,
                                         scan: 1'b0, last: 1'b0};

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          frame_start;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk         (clk_pixel),
        .rst         (reset),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .active      (active),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    scan_state_t state_reg, state_next;
    logic        first_frame_reg, first_frame_next;
    logic        underflow_reg, underflow_next;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            first_frame_reg <= 1'b1;
            underflow_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            first_frame_reg <= first_frame_next;
            underflow_reg   <= underflow_next;
        end
    end

    // state_next is also the mode of the current cycle, so pixel (0,0) belongs to the new frame.
    always_comb begin
        state_next       = state_reg;
        first_frame_next = first_frame_reg;
        underflow_next   = underflow_reg;
        if (frame_start) begin
            first_frame_next = 1'b0;
            if (ableToRead) begin
                state_next = ST_SCAN;
            end else if (first_frame_reg) begin
                state_next = ST_IDLE;
            end else begin
                state_next     = ST_SKIP;
                underflow_next = 1'b1;
            end
        end
    end

    logic       req_active;
    video_tag_t tag_in;

    assign req_active   = active && (state_next == ST_SCAN);
    assign tag_in.hsync = hsync;
    assign tag_in.vsync = vsync;
    assign tag_in.blank = !(active && (state_next != ST_IDLE));
    assign tag_in.scan  = req_active;
    assign tag_in.last  = req_active && (int'(hcnt) == H_ACTIVE - 1) &&
                          (int'(vcnt) == V_ACTIVE - 1);

    logic                     req_strobe_reg;
    logic [PIXEL_COORD_W-1:0] req_x_reg;
    logic [PIXEL_COORD_W-1:0] req_y_reg;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            req_strobe_reg <= 1'b0;
            req_x_reg      <= '0;
            req_y_reg      <= '0;
        end else begin
            req_strobe_reg <= req_active;
            req_x_reg      <= PIXEL_COORD_W'(hcnt);
            req_y_reg      <= PIXEL_COORD_W'(vcnt);
        end
    end

    // One stage for the request register plus READ_LATENCY stages for the buffer.
    video_tag_t pipe_reg [PIPE_D];
    logic       end_of_read_reg;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_D; i++) begin
                pipe_reg[i] <= TAG_RESET;
            end
            end_of_read_reg <= 1'b0;
        end else begin
            pipe_reg[0] <= tag_in;
            for (int i = 1; i < PIPE_D; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
            end_of_read_reg <= pipe_reg[PIPE_D-1].last;
        end
    end

    video_tag_t out_tag;
    assign out_tag = pipe_reg[PIPE_D-1];

    assign readPixelSignal = req_strobe_reg;
    assign readPixelX      = req_x_reg;
    assign readPixelY      = req_y_reg;
    assign endOfRead       = end_of_read_reg;
    assign vga_r           = out_tag.scan ? readPixel[23:16] : 8'd0;
    assign vga_g           = out_tag.scan ? readPixel[15:8]  : 8'd0;
    assign vga_b           = out_tag.scan ? readPixel[7:0]   : 8'd0;
    assign vga_hsync       = out_tag.hsync;
    assign vga_vsync       = out_tag.vsync;
    assign vga_blank       = out_tag.blank;
    assign underflow       = underflow_reg;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout on a tiny 14x7 raster with a one-clock buffer model.
// Expected requests/video are pushed per counter cycle and popped when the output stage shows them.
module tb_framebuffer_scanout;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FRAME = HT * VT;

    logic        clk_pixel = 1'b0;
    logic        reset = 1'b1;
    logic        ableToRead = 1'b0;
    logic [23:0] readPixel = 24'd0;
    logic [20:0] readPixelX;
    logic [20:0] readPixelY;
    logic        readPixelSignal;
    logic        endOfRead;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank;
    logic        underflow;

    always #5 clk_pixel = ~clk_pixel;

    framebuffer_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .READ_LATENCY(1)
    ) dut (
        .clk_pixel       (clk_pixel),
        .reset           (reset),
        .ableToRead      (ableToRead),
        .readPixel       (readPixel),
        .readPixelX      (readPixelX),
        .readPixelY      (readPixelY),
        .readPixelSignal (readPixelSignal),
        .endOfRead       (endOfRead),
        .vga_r           (vga_r),
        .vga_g           (vga_g),
        .vga_b           (vga_b),
        .vga_hsync       (vga_hsync),
        .vga_vsync       (vga_vsync),
        .vga_blank       (vga_blank),
        .underflow       (underflow)
    );

    // Buffer read port: data returns one clock after the strobe.
    always @(posedge clk_pixel) begin
        if (readPixelSignal === 1'b1) begin
            readPixel <= {readPixelX[7:0], readPixelY[7:0], 8'h5A};
        end
    end

    typedef struct {
        logic       strobe;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       last;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    exp_t sb_q[$];

    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;
    int   tb_h, tb_v, tb_mode;
    logic tb_first, tb_uf, last_popped;
    int   strb_cnt, eor_cnt, blank_lo_cnt, last_eor_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_t r;
        sb_q.delete();
        r.strobe = 1'b0; r.hs = 1'b0; r.vs = 1'b0; r.blank = 1'b1; r.last = 1'b0;
        r.x = 8'd0; r.y = 8'd0; r.r = 8'd0; r.g = 8'd0; r.b = 8'd0;
        sb_q.push_back(r);
        tb_h = 0; tb_v = 0; tb_mode = 0;
        tb_first = 1'b1; tb_uf = 1'b0; last_popped = 1'b0;
    endtask

    task automatic clear_stats();
        strb_cnt = 0; eor_cnt = 0; blank_lo_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_blank"}, vga_blank, 1'b1);
        check({tag, "_hsync"}, vga_hsync, 1'b0);
        check({tag, "_vsync"}, vga_vsync, 1'b0);
        check({tag, "_strobe"}, readPixelSignal, 1'b0);
        check({tag, "_eor"}, endOfRead, 1'b0);
        check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 24'd0);
        check({tag, "_underflow"}, underflow, 1'b0);
        check({tag, "_x"}, readPixelX, 21'd0);
        check({tag, "_y"}, readPixelY, 21'd0);
    endtask

    // One pixel clock: predict this counter cycle, clock, then compare.
    task automatic step();
        exp_t e, o;
        bit   act;
        if (tb_h == 0 && tb_v == 0) begin
            if (ableToRead) tb_mode = 1;
            else if (tb_first) tb_mode = 0;
            else begin
                tb_mode = 2;
                tb_uf = 1'b1;
            end
            tb_first = 1'b0;
        end
        act      = (tb_h < 8) && (tb_v < 4);
        e.strobe = act && (tb_mode == 1);
        e.x      = 8'(tb_h);
        e.y      = 8'(tb_v);
        e.hs     = (tb_h >= 10) && (tb_h < 12);
        e.vs     = (tb_v == 5);
        e.blank  = !(act && (tb_mode != 0));
        e.last   = e.strobe && (tb_h == 7) && (tb_v == 3);
        e.r      = e.strobe ? 8'(tb_h) : 8'd0;
        e.g      = e.strobe ? 8'(tb_v) : 8'd0;
        e.b      = e.strobe ? 8'h5A : 8'd0;
        sb_q.push_back(e);
        tb_h++;
        if (tb_h == HT) begin
            tb_h = 0;
            tb_v = (tb_v == VT - 1) ? 0 : tb_v + 1;
        end

        @(posedge clk_pixel);
        #1;
        cyc++;
        check("strobe", readPixelSignal, e.strobe);
        if (e.strobe) begin
            check("req_x", readPixelX, 21'(e.x));
            check("req_y", readPixelY, 21'(e.y));
        end
        check("underflow", underflow, tb_uf);
        if (sb_q.size() == 2) begin
            o = sb_q.pop_front();
            check("hsync", vga_hsync, o.hs);
            check("vsync", vga_vsync, o.vs);
            check("blank", vga_blank, o.blank);
            check("vga_r", vga_r, o.r);
            check("vga_g", vga_g, o.g);
            check("vga_b", vga_b, o.b);
            check("eor", endOfRead, last_popped);
            last_popped = o.last;
        end
        if (readPixelSignal === 1'b1) strb_cnt++;
        if (vga_blank === 1'b0) blank_lo_cnt++;
        if (endOfRead === 1'b1) begin
            eor_cnt++;
            if (last_eor_cyc >= 0) check("eor_interval", cyc - last_eor_cyc, FRAME);
            last_eor_cyc = cyc;
        end
    endtask

    initial begin
        reset = 1'b1;
        ableToRead = 1'b1;
        repeat (3) @(posedge clk_pixel);
        #1;
        check_reset_outputs("rst");

        // Three committed frames back to back.
        reset = 1'b0;
        model_reset();
        clear_stats();
        last_eor_cyc = -1;
        repeat (3 * FRAME) step();
        check("scan3_strobes", strb_cnt, 96);
        check("scan3_blank_lo", blank_lo_cnt, 96);
        check("scan3_eor", eor_cnt, 3);
        $display("scan x3: strobes=%0d blank_lo=%0d eor=%0d", strb_cnt, blank_lo_cnt, eor_cnt);

        // Buffer not ready at frame start: frame dropped, raising mid-frame changes nothing.
        ableToRead = 1'b0;
        clear_stats();
        last_eor_cyc = -1;
        repeat (5) step();
        ableToRead = 1'b1;
        repeat (FRAME - 5) step();
        check("skip_strobes", strb_cnt, 0);
        check("skip_blank_lo", blank_lo_cnt, 32);
        check("skip_eor", eor_cnt, 0);
        check("skip_underflow", underflow, 1'b1);
        $display("skip: strobes=%0d blank_lo=%0d eor=%0d uf=%0b", strb_cnt, blank_lo_cnt, eor_cnt, underflow);

        clear_stats();
        repeat (FRAME) step();
        check("resume_strobes", strb_cnt, 32);
        check("resume_eor", eor_cnt, 1);
        check("resume_underflow", underflow, 1'b1);
        $display("resume: strobes=%0d eor=%0d uf=%0b", strb_cnt, eor_cnt, underflow);

        // Drop ableToRead at line 2 of a committed frame.
        clear_stats();
        repeat (2 * HT) step();
        ableToRead = 1'b0;
        repeat (FRAME - 2 * HT) step();
        ableToRead = 1'b1;
        check("midchg_strobes", strb_cnt, 32);
        check("midchg_eor", eor_cnt, 1);
        $display("mid-frame drop: strobes=%0d eor=%0d", strb_cnt, eor_cnt);

        // Reset at line 2, then a clean frame from counter zero.
        clear_stats();
        repeat (2 * HT) step();
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) begin
            @(posedge clk_pixel);
            #1;
            check_reset_outputs("midrst_hold");
        end
        reset = 1'b0;
        model_reset();
        clear_stats();
        last_eor_cyc = -1;
        repeat (FRAME) step();
        check("after_rst_strobes", strb_cnt, 32);
        check("after_rst_eor", eor_cnt, 1);
        $display("after reset: strobes=%0d eor=%0d uf=%0b", strb_cnt, eor_cnt, underflow);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
Read-side consumer of the triple frame buffer. Generates DVI/VGA raster timing and issues one pixel read per active pixel through the buffer's read port (readPixelX/readPixelY/readPixelSignal -> readPixel). Returns each frame with a one-cycle endOfRead pulse so the buffer can rotate. Sits between the frame buffer and the TMDS encoder, in the pixel clock domain.

Parameters:
H_ACTIVE, 1920, visible pixels per line
H_FP, 88, horizontal front porch (clocks)
H_SYNC, 44, hsync width (clocks)
H_BP, 148, horizontal back porch (clocks)
V_ACTIVE, 1080, visible lines
V_FP, 4, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 36, vertical back porch (lines)
READ_LATENCY, 1, clocks from readPixelSignal to valid readPixel (1..4)

Ports:
clk_pixel  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
ableToRead  in  1  frame buffer has a readable frame
readPixel  in  24  RGB888 returned by the buffer
readPixelX  out  21  requested column
readPixelY  out  21  requested row
readPixelSignal  out  1  read strobe, one per active pixel
endOfRead  out  1  one-cycle pulse, frame fully consumed
vga_r / vga_g / vga_b  out  8 each  pixel colour
vga_hsync  out  1  horizontal sync, active-high
vga_vsync  out  1  vertical sync, active-high
vga_blank  out  1  high outside active area
underflow  out  1  sticky: a frame started with ableToRead low

Behaviour:
- Reset (async, active-high): hcnt=vcnt=0, state IDLE, pipeline cleared. All outputs 0 except vga_blank=1.
- Counters: hcnt 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. vcnt advances when hcnt wraps, range 0..V_TOTAL-1.
- Active area: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
- hsync=1 for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule on vcnt.
- Timing runs free in every state.
- States:
  - IDLE: timing only, blank video, no requests.
  - SCAN: frame is committed.
  - SKIP: frame is dropped.
- Transitions:
  - Evaluated only at frame start (hcnt=0, vcnt=0), from any state.
  - ableToRead=1 -> SCAN.
  - Else -> SKIP, and underflow is set (not set for the IDLE->IDLE/SKIP decision on the very first frame after reset).
  - A mid-frame change of ableToRead is ignored.
- SCAN requests:
  - readPixelSignal=1 exactly in active cycles.
  - readPixelX=hcnt and readPixelY=vcnt, zero-extended to 21 bits, registered together with the strobe.
- Alignment: hsync, vsync, blank and a SCAN/SKIP tag are delayed by READ_LATENCY+1 registers, so readPixel lines up with its sync.
- Colour output:
  - SCAN and active: vga_rgb = readPixel {r[23:16], g[15:8], b[7:0]}.
  - Otherwise: 0.
- SKIP: active area output black with blank=0. No requests, no endOfRead.
- endOfRead:
  - Asserted one cycle, on the clock after the data for the last active pixel (H_ACTIVE-1, V_ACTIVE-1) reaches the output stage.
  - SCAN frames only; never two pulses per frame.
- underflow: cleared only by reset.
- Reset mid-frame: everything returns to reset values immediately. No endOfRead is emitted for the aborted frame.

Decomposition:
- Package framebuffer_pkg:
  - Scanout state enum (IDLE/SCAN/SKIP).
  - PIXEL_COORD_W=21, RGB_W=24.
  - Default 1080p timing constants.
  - The H_TOTAL/V_TOTAL width helper ($clog2).
- Sub-module video_timing_gen: counters, active flag, hsync/vsync, frame-start pulse.
- framebuffer_scanout holds the state machine, request generation, latency pipeline and endOfRead.

Test Plan:
- Sim parameters: H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), READ_LATENCY=1. Buffer model returns {X,Y} encoded into readPixel one clock after the strobe.
- Timing: hold ableToRead=1 -> hsync high on hcnt 10..11, vsync high on lines 5, blank low 32 cycles per 98-cycle frame, readPixelSignal count = 32 per frame.
- Data alignment: model returns readPixel = {8'(X),8'(Y),8'h5A} -> first active output cycle shows r=0,g=0,b=0x5A; pixel (7,3) shows r=7,g=3. All outputs are two clocks after their request.
- endOfRead: 3 consecutive frames with ableToRead=1 -> exactly 3 single-cycle pulses, each 98 cycles apart, the clock after pixel (7,3) is output.
- Underflow/skip: ableToRead=0 at frame start of frame 2 -> no strobes and black active area that frame, underflow=1 and stays 1. Raise ableToRead -> frame 3 returns to SCAN.
- Mid-frame change: drop ableToRead at line 2 of a SCAN frame -> all 32 requests still issued and endOfRead still pulses. Assert reset at line 2 -> blank=1, no strobe, no endOfRead, counters restart at 0 after release.
